// File: rtl/fifo_wr_packer_pkg.sv
// Shared sizing helpers for the write-side packer: beats-per-word ratio,
// beat-counter width and the width legality check used at elaboration.
package fifo_wr_packer_pkg;

  function automatic int calc_ratio(input int in_w, input int out_w);
    return out_w / in_w;
  endfunction

  function automatic int calc_cnt_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // A word must hold a whole number of beats, and at least two of them.
  function automatic bit widths_ok(input int in_w, input int out_w);
    return (in_w > 0) && (out_w % in_w == 0) && (out_w / in_w >= 2);
  endfunction

endpackage

// File: rtl/fifo_wr_packer_slot.sv
// Single-entry word holding register. A load takes priority over a clear,
// and a clear only drops valid so the held data stays stable.
module wr_word_slot #(
  parameter int W = 8
) (
  input  logic         wclk,
  input  logic         wrstn,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         clear,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_wr_packer.sv
// Packs RATIO narrow beats (beat 0 in the LSBs) into one FIFO word, closing a
// word early on s_last, and feeds the FIFO write port while honouring wfull.
//
// Handshakes: a beat moves when s_valid & s_ready on a wclk edge; a word
// leaves when winc is high on a wclk edge (winc = out_valid & ~wfull).
module fifo_wr_packer
  import fifo_wr_packer_pkg::*;
#(
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 wclk,
  input  logic                 wrstn,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic                 s_last,
  input  logic                 wfull,
  output logic                 winc,
  output logic [OUT_WIDTH-1:0] wdata,
  output logic [15:0]          pkt_count,
  output logic                 busy
);

  localparam int RATIO = calc_ratio(IN_WIDTH, OUT_WIDTH);
  localparam int CNT_W = calc_cnt_w(RATIO);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  if (!widths_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_widths
    $error("fifo_wr_packer: OUT_WIDTH must be a multiple of IN_WIDTH with at least two beats");
  end

  logic [OUT_WIDTH-1:0] pack_data;
  logic [CNT_W-1:0]     pack_cnt;
  logic [OUT_WIDTH-1:0] word_next;
  logic [OUT_WIDTH-1:0] asm_word;
  logic [OUT_WIDTH-1:0] out_data;
  logic [OUT_WIDTH-1:0] out_load_data;
  logic                 asm_full;
  logic                 out_valid;
  logic                 out_free;
  logic                 accept;
  logic                 complete;
  logic                 move;
  logic                 bypass;
  logic                 park;
  logic                 out_load;
  int unsigned          lane;

  assign winc     = out_valid & ~wfull;
  assign wdata    = out_data;
  assign out_free = ~out_valid | winc;
  assign s_ready  = ~asm_full | out_free;
  assign accept   = s_valid & s_ready;
  assign complete = accept & (s_last | (pack_cnt == LAST_CNT));

  // The parked word always goes out first, so a word completing on the same
  // edge as that move must itself park rather than jump the queue.
  assign move     = asm_full & out_free;
  assign bypass   = complete & out_free & ~move;
  assign park     = complete & ~bypass;
  assign out_load = move | bypass;

  assign busy = (pack_cnt != '0) | asm_full | out_valid;

  // The partial word is zeroed on completion, so lanes above the closing
  // beat are already zero in word_next.
  always_comb begin
    lane      = 32'(pack_cnt) * 32'(IN_WIDTH);
    word_next = pack_data;
    word_next[lane +: IN_WIDTH] = s_data;
  end

  always_comb begin
    out_load_data = word_next;
    if (move) begin
      out_load_data = asm_word;
    end
  end

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      pack_data <= '0;
      pack_cnt  <= '0;
    end else if (accept) begin
      if (complete) begin
        pack_data <= '0;
        pack_cnt  <= '0;
      end else begin
        pack_data <= word_next;
        pack_cnt  <= pack_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      pkt_count <= '0;
    end else if (accept && s_last) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end

  wr_word_slot #(.W(OUT_WIDTH)) u_asm_slot (
    .wclk      (wclk),
    .wrstn     (wrstn),
    .load      (park),
    .load_data (word_next),
    .clear     (move),
    .valid     (asm_full),
    .data      (asm_word)
  );

  wr_word_slot #(.W(OUT_WIDTH)) u_out_slot (
    .wclk      (wclk),
    .wrstn     (wrstn),
    .load      (out_load),
    .load_data (out_load_data),
    .clear     (out_free),
    .valid     (out_valid),
    .data      (out_data)
  );

endmodule
